sum_sequencer: RTL
==================

SUM_SEQUENCER -- requirements
Module: sum_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of operand entries (power of two, 2..16).
REQ-002 SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits.
REQ-003 SHALL have port clk, input, 1 bit, meaning system clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1 bit, meaning reset (synchronous, active-high).
REQ-005 SHALL have port wr_valid, input, 1 bit, meaning operand write request.
REQ-006 SHALL have port wr_addr, input, $clog2(DEPTH) bits, meaning operand entry index.
REQ-007 SHALL have port wr_data, input, WIDTH bits, meaning operand value.
REQ-008 SHALL have port wr_ready, output, 1 bit, meaning writes accepted this cycle.
REQ-009 SHALL have port start, input, 1 bit, meaning begin summation request.
REQ-010 SHALL have port count, input, $clog2(DEPTH)+1 bits, meaning number of entries to sum, starting at entry 0.
REQ-011 SHALL have port busy, output, 1 bit, meaning summation in progress.
REQ-012 SHALL have port done, output, 1 bit, meaning one-cycle result-valid pulse.
REQ-013 SHALL have port sum, output, WIDTH bits, meaning last completed result, held until next done.
REQ-014 SHALL have port ovf, output, 1 bit, meaning last result exceeded 2^WIDTH-1.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; wr_ready=1 only in IDLE; busy=1 in RUN and DONE.
REQ-016 SHALL write wr_data to entry wr_addr on the edge where wr_valid && wr_ready; writes in RUN/DONE are dropped.
REQ-017 SHALL, in IDLE with start=1, latch count (values >DEPTH clamped to DEPTH), clear accumulator and carry flag, and enter RUN; count=0 enters DONE directly.
REQ-018 SHALL, when start and an accepted write coincide, commit the write first so the summation uses the new value.
REQ-019 SHALL, in RUN, add one entry per cycle in ascending index 0..count-1, entering DONE after the last add.
REQ-020 SHALL, in DONE, assert done for exactly one cycle, update sum and ovf on that same edge, and return to IDLE.
REQ-021 SHALL give latency: start sampled at edge T -> done high in cycle following edge T+count+1 (count=0: T+1).
REQ-022 SHALL ignore start while busy=1.
REQ-023 SHALL, without saturation, compute sum modulo 2^WIDTH and set ovf if any add produced a carry-out.

Reset
REQ-024 SHALL, on reset, force IDLE, sum=0, ovf=0, done=0, busy=0, accumulator=0, and all operand entries=0.
REQ-025 SHALL, on reset during RUN or DONE, abort with no done pulse; wr_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-026 SHALL, with macro SUM_SEQUENCER_SATURATE_EN defined, clamp the accumulator to 2^WIDTH-1 at the first overflowing add, hold it there, and set ovf=1.
REQ-027 SHALL, without SUM_SEQUENCER_SATURATE_EN, use wrap-around arithmetic per REQ-023; all other behaviour is identical.

Verification
REQ-028 SHALL cover: load entries 0..6 = 1,5,9,2,6,7,1, start count=7 -> done 8 cycles after start, sum=31, ovf=0.
REQ-029 SHALL cover: all 8 entries=200, count=8 -> sum=64, ovf=1; with SUM_SEQUENCER_SATURATE_EN sum=255, ovf=1.
REQ-030 SHALL cover: start count=0 -> done next cycle, sum=0, ovf=0; start count=12 -> treated as 8.
REQ-031 SHALL cover: wr_valid and a second start during RUN -> wr_ready=0, entry unchanged, no extra done, result unaffected.
REQ-032 SHALL cover: reset asserted at 3rd RUN cycle -> no done pulse, sum=0, entries read back 0 via sum of count=8.
REQ-033 SHALL cover: write entry 0=9 with start in same cycle, count=1 -> sum=9.

Source files
------------

// File: rtl/sum_sequencer.sv
// Sums entries 0..count-1 of a small operand register file, one add per cycle.
// Optional build macro SUM_SEQUENCER_SATURATE_EN: saturating accumulation instead of wrap-around.
module sum_sequencer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_ready,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         sum,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Handshake: a write is accepted on the rising edge where wr_valid && wr_ready;
  // wr_ready is high only while idle, so writes presented while busy are dropped.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    idx_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             ovf_q;
  logic             done_q;

  logic [CW-1:0]    count_clamped;
  logic [WIDTH-1:0] add_s;
  logic             add_c;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry_nxt;

  assign count_clamped = (count > DEPTH_C) ? DEPTH_C : count;
  assign {add_c, add_s} = {1'b0, acc_q} + {1'b0, mem[idx_q[AW-1:0]]};
  assign carry_nxt = carry_q | add_c;

`ifdef SUM_SEQUENCER_SATURATE_EN
  // Once any add has overflowed the accumulator stays pinned at full scale.
  assign acc_nxt = carry_nxt ? {WIDTH{1'b1}} : add_s;
`else
  assign acc_nxt = add_s;
`endif

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (start) begin
          state_nxt = (count_clamped == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (idx_q == count_q - CW'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      // The write commits on the start edge, so the first add already sees it.
      if (wr_valid && wr_ready) begin
        mem[wr_addr] <= wr_data;
      end
      case (state)
        IDLE: begin
          if (start) begin
            count_q <= count_clamped;
            idx_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
          end
        end
        RUN: begin
          acc_q   <= acc_nxt;
          carry_q <= carry_nxt;
          idx_q   <= idx_q + CW'(1);
        end
        DONE: begin
          done_q <= 1'b1;
          sum_q  <= acc_q;
          ovf_q  <= carry_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign done = done_q;
  assign sum  = sum_q;
  assign ovf  = ovf_q;

endmodule
